// File: rtl/reg_scoreboard.sv
// Register-write scoreboard: tracks in-flight writers per register and stalls ID on unforwardable sources.
// Optional stall statistics counter is built when SCOREBOARD_STATS_EN is defined.
module reg_scoreboard #(
  parameter int NREG  = 32,
  parameter int LAT_W = 4,
  localparam int RS_WIDTH = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [RS_WIDTH-1:0] rs1_id,
  input  logic [RS_WIDTH-1:0] rs2_id,
  input  logic                rs1_used,
  input  logic                rs2_used,
  input  logic                issue_valid,
  input  logic                issue_regwrite,
  input  logic [RS_WIDTH-1:0] issue_rd,
  input  logic [LAT_W-1:0]    issue_lat,
  input  logic                wb_valid,
  input  logic                wb_regwrite,
  input  logic [RS_WIDTH-1:0] wb_rd,
  input  logic                kill_valid,
  input  logic [RS_WIDTH-1:0] kill_rd,
  output logic                stall_id,
  output logic [NREG-1:0]     pending_mask,
  output logic                busy_any,
  output logic                err_ovf,
  output logic [31:0]         stall_cycles
);

  logic [1:0]       pend     [NREG];
  logic [1:0]       pend_nxt [NREG];
  logic [LAT_W-1:0] ttl      [NREG];
  logic [LAT_W-1:0] ttl_nxt  [NREG];
  logic [NREG-1:0]  inc;
  logic [NREG-1:0]  dec_wb;
  logic [NREG-1:0]  dec_kill;
  logic [NREG-1:0]  step_err;
  logic [NREG-1:0]  mask_nxt;
  logic             issue_ev;
  logic             wb_ev;
  logic             kill_ev;
  logic             hz1;
  logic             hz2;

  // Saturating writer-count step; returns {error, next_count}.
  function automatic logic [2:0] pend_step(input logic [1:0] cur, input logic up_one,
                                           input logic dn_a, input logic dn_b);
    logic [2:0] up;
    logic [2:0] dn;
    logic [2:0] diff;
    up   = {1'b0, cur} + {2'b00, up_one};
    dn   = {2'b00, dn_a} + {2'b00, dn_b};
    diff = up - dn;
    if (up < dn) begin
      pend_step = {1'b1, 2'd0};
    end else if (diff > 3'd3) begin
      pend_step = {1'b1, 2'd3};
    end else begin
      pend_step = {1'b0, diff[1:0]};
    end
  endfunction

  assign issue_ev = issue_valid & issue_regwrite & (issue_rd != RS_WIDTH'(0));
  assign wb_ev    = wb_valid & wb_regwrite & (wb_rd != RS_WIDTH'(0));
  assign kill_ev  = kill_valid & (kill_rd != RS_WIDTH'(0));

  // Decode the three events into per-register one-hot strobes.
  always_comb begin
    inc      = {NREG{1'b0}};
    dec_wb   = {NREG{1'b0}};
    dec_kill = {NREG{1'b0}};
    for (int r = 1; r < NREG; r++) begin
      inc[r]      = issue_ev && (issue_rd == RS_WIDTH'(r));
      dec_wb[r]   = wb_ev && (wb_rd == RS_WIDTH'(r));
      dec_kill[r] = kill_ev && (kill_rd == RS_WIDTH'(r));
    end
  end

  // Next writer count and countdown per register; x0 is pinned at zero.
  always_comb begin
    step_err = {NREG{1'b0}};
    mask_nxt = {NREG{1'b0}};
    for (int r = 0; r < NREG; r++) begin
      pend_nxt[r] = 2'd0;
      ttl_nxt[r]  = {LAT_W{1'b0}};
      if (r != 0) begin
        {step_err[r], pend_nxt[r]} = pend_step(pend[r], inc[r], dec_wb[r], dec_kill[r]);
        if (inc[r]) begin
          ttl_nxt[r] = issue_lat;
        end else if (pend_nxt[r] == 2'd0) begin
          ttl_nxt[r] = {LAT_W{1'b0}};
        end else if (ttl[r] != {LAT_W{1'b0}}) begin
          ttl_nxt[r] = ttl[r] - {{(LAT_W-1){1'b0}}, 1'b1};
        end else begin
          ttl_nxt[r] = {LAT_W{1'b0}};
        end
      end else begin
        pend_nxt[r] = 2'd0;
        ttl_nxt[r]  = {LAT_W{1'b0}};
      end
      mask_nxt[r] = (pend_nxt[r] != 2'd0);
    end
  end

  // Scoreboard state and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) begin
        pend[r] <= 2'd0;
        ttl[r]  <= {LAT_W{1'b0}};
      end
      pending_mask <= {NREG{1'b0}};
      err_ovf      <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        pend[r] <= pend_nxt[r];
        ttl[r]  <= ttl_nxt[r];
      end
      pending_mask <= mask_nxt;
      err_ovf      <= err_ovf | (|step_err);
    end
  end

  // Hazard detection looks only at registered countdowns.
  always_comb begin
    hz1 = 1'b0;
    hz2 = 1'b0;
    if (rs1_used && (rs1_id != RS_WIDTH'(0)) && (int'(rs1_id) < NREG)) begin
      hz1 = (ttl[rs1_id] != {LAT_W{1'b0}});
    end else begin
      hz1 = 1'b0;
    end
    if (rs2_used && (rs2_id != RS_WIDTH'(0)) && (int'(rs2_id) < NREG)) begin
      hz2 = (ttl[rs2_id] != {LAT_W{1'b0}});
    end else begin
      hz2 = 1'b0;
    end
  end

  assign stall_id = hz1 | hz2;
  assign busy_any = |pending_mask;

`ifdef SCOREBOARD_STATS_EN
  logic [31:0] stall_cnt;

  // Free-running stall cycle counter, wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= 32'd0;
    end else if (stall_id) begin
      stall_cnt <= stall_cnt + 32'd1;
    end else begin
      stall_cnt <= stall_cnt;
    end
  end

  assign stall_cycles = stall_cnt;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Register-write scoreboard for the 5-stage pipeline, on the producer side of the forwarding path. Tracks every in-flight register write from ID issue to WB retire, plus a per-register countdown until the newest writer's result can be forwarded. When a source register in ID is not yet forwardable (load-use, multi-cycle mul/div), it raises `stall_id`. The forwarding unit still picks the bypass source; this block only decides whether ID may advance.

## Interface
Parameters:
- `NREG`, 32: architectural register count; x0 is never tracked.
- `LAT_W`, 4: width of the per-register countdown and of `issue_lat`.

Ports:
- `clk` in 1: clock; all state updates on its rising edge.
- `rst` in 1: reset; synchronous, active-low. Clears all state when low at a rising `clk`.
- `rs1_id` in `RS_WIDTH`: source register 1 of the instruction in ID.
- `rs2_id` in `RS_WIDTH`: source register 2 of the instruction in ID.
- `rs1_used` in 1: the ID instruction reads rs1.
- `rs2_used` in 1: the ID instruction reads rs2.
- `issue_valid` in 1: the ID instruction moves to EX this cycle.
- `issue_regwrite` in 1: the issuing instruction writes `issue_rd`.
- `issue_rd` in `RS_WIDTH`: destination register of the issuing instruction.
- `issue_lat` in `LAT_W`: cycles its result is not forwardable (ALU 0, load 1, mul/div N).
- `wb_valid` in 1: an instruction retires in WB this cycle.
- `wb_regwrite` in 1: the retiring instruction writes `wb_rd`.
- `wb_rd` in `RS_WIDTH`: destination register of the retiring instruction.
- `kill_valid` in 1: a squashed in-flight writer is cancelled this cycle.
- `kill_rd` in `RS_WIDTH`: destination register of the killed writer.
- `stall_id` out 1: combinational; hold ID and insert a bubble into EX.
- `pending_mask` out `NREG`: bit r is 1 iff `pend[r] != 0`; registered.
- `busy_any` out 1: OR of `pending_mask`.
- `err_ovf` out 1: sticky; set on pend overflow or underflow.
- `stall_cycles` out 32: stall statistics counter (see Configuration).

## Operation
- Per register r (1..NREG-1), the block keeps:
  - `pend[r]`, 2 bits: count of in-flight writers, range 0..3.
  - `ttl[r]`, `LAT_W` bits: cycles until the newest writer is forwardable.
- Register 0 state stays 0 forever; any event naming rd=0 is ignored.
- Issue event: `issue_valid & issue_regwrite & issue_rd!=0`.
- Retire event: `wb_valid & wb_regwrite & wb_rd!=0`.
- Kill event: `kill_valid & kill_rd!=0`.
- Per cycle, for each r, the next `pend` is pend + inc − dec_wb − dec_kill.
  - If this is >3, `pend` saturates at 3 and `err_ovf` is set.
  - If this is <0, `pend` clamps to 0 and `err_ovf` is set.
- Per cycle, for each r, the next `ttl` is chosen in priority order:
  1. Issue to r: `ttl` ← `issue_lat`.
  2. Next `pend` is 0: `ttl` ← 0.
  3. Otherwise: `ttl` ← max(`ttl` − 1, 0).
- Hazard terms:
  - hz1 = `rs1_used & rs1_id!=0 & ttl[rs1_id]!=0`; hz2 is defined the same way for rs2.
  - `stall_id` = hz1 | hz2.
- `stall_id` reads registered state only. Issue/retire/kill in the same cycle do not affect it until the next cycle.
- Control must not assert `issue_valid` while `stall_id` is 1. If it does anyway, the event is applied as normal.

## Timing
- Reset (`rst`=0 at an edge): all `pend`=0, `ttl`=0, `err_ovf`=0, `pending_mask`=0, `busy_any`=0, `stall_cycles`=0. `stall_id` is therefore 0 from the next cycle.
- Reset applied mid-operation discards every in-flight record; there is no draining.
- Issue at edge k with `issue_lat`=L: a consumer in ID sees `stall_id`=1 for cycles k+1..k+L, then 0 at k+L+1.
  - L=0: no stall.
  - Load (L=1): exactly one bubble.
- `pending_mask` updates one cycle after the event. `busy_any` is combinational from `pending_mask`.
- Simultaneous issue and retire, same rd: `pend` is unchanged and `ttl` ← `issue_lat`.
- Simultaneous issue, retire and kill, same rd: net `pend` is −1 and `ttl` ← `issue_lat`.
- A kill that drops `pend` to 0 clears `ttl` in the same edge. A pending stall on that register releases next cycle.
- `ttl` never wraps below 0. `issue_lat` = 2^LAT_W−1 is legal.

## Configuration
- `SCOREBOARD_STATS_EN`:
  - Defined: `stall_cycles` is a 32-bit counter, incremented on every edge where `stall_id`=1 and `rst`=1. It wraps at 2^32 to 0 and is cleared by reset.
  - Undefined: `stall_cycles` is tied to 0 and no counter flops are built.

## Test plan
- Reset with stray inputs: drive `rst`=0 for 2 cycles with issue_rd=5 → `pending_mask`=0, `stall_id`=0, `err_ovf`=0 afterwards.
- Load-use: issue x3 with lat=1, then ID rs1=3 used → `stall_id`=1 for exactly 1 cycle; `pending_mask[3]`=1 until a WB retire of x3.
- Divide: issue x7 with lat=5, ID rs2=7 used → 5 stall cycles. With the macro defined, `stall_cycles`=5.
- x0 and unused operands: issue x0 with lat=3, then rs1=0 → no stall and `pending_mask`=0. Issue x4 with lat=2, then rs2=4 but `rs2_used`=0 → no stall.
- Same-cycle events: x9 pend=1 (ttl=0) gets a retire of x9 and an issue to x9 with lat=2 in the same cycle → pend stays 1, ttl=2. A kill of x9 next cycle → pend=0, stall drops the following cycle.
- Overflow/underflow: 4 issues to x2 with no retire → pend=3 and `err_ovf`=1 (sticky). After reset, a retire of x2 with pend=0 → `err_ovf`=1.
